// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU datapath: widths,
// opcode values, ACC source encodings and the ALU-op classifier.
package cpu_pkg;

    localparam int DATA_W    = 8;
    localparam int PC_W      = 8;
    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = 2;

    // Opcodes double as ALU select codes where the two overlap.
    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_MOVA = 4'b0101;
    localparam logic [3:0] OP_JZ   = 4'b0110;
    localparam logic [3:0] OP_JZIM = 4'b0111;
    localparam logic [3:0] OP_JC   = 4'b1000;
    localparam logic [3:0] OP_JCIM = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_LDIM = 4'b1101;

    typedef enum logic [1:0] {
        ACC_SRC_ALU  = 2'b00,
        ACC_SRC_HOLD = 2'b01,
        ACC_SRC_REG  = 2'b10,
        ACC_SRC_IMM  = 2'b11
    } acc_src_e;

    function automatic logic is_alu_op(input logic [3:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB) || (sel == OP_NOR) ||
               (sel == OP_SHL) || (sel == OP_SHR);
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add, subtract with borrow, NOR, shift left/right;
// any other select code passes a through with cout cleared.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        sel,
    output logic [DATA_W-1:0] y,
    output logic              cout
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y    = a;
        cout = 1'b0;
        case (sel)
            OP_ADD: begin
                y    = sum[DATA_W-1:0];
                cout = sum[DATA_W];
            end
            OP_SUB: begin
                y    = a - b;
                cout = (a < b);
            end
            OP_NOR: y = ~(a | b);
            OP_SHL: begin
                y    = {a[DATA_W-2:0], 1'b0};
                cout = a[DATA_W-1];
            end
            OP_SHR: begin
                y    = {1'b0, a[DATA_W-1:1]};
                cout = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC, IR, ACC, R0..R3 and z/c flags.
// Define DP_R0_ZERO_EN to make R0 a hardwired zero register.
module cpu_datapath
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              CLR,
    input  logic              LoadIR,
    input  logic              IncPC,
    input  logic              SelPC,
    input  logic              LoadPC,
    input  logic              LoadReg,
    input  logic              LoadAcc,
    input  logic [1:0]        SelACC,
    input  logic [3:0]        SelALU,
    input  logic [7:0]        imem_data,
    output logic [PC_W-1:0]   imem_addr,
    output logic [3:0]        op,
    output logic              z,
    output logic              c
);

    logic [PC_W-1:0]      pc;
    logic [7:0]           ir;
    logic [DATA_W-1:0]    acc;
    logic [DATA_W-1:0]    regs [NUM_REGS];

    logic [REG_IDX_W-1:0] reg_idx;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    reg_rd;
    logic                 reg_we;
    logic [DATA_W-1:0]    alu_y;
    logic                 alu_cout;
    logic                 jump_cond;
    logic                 flag_we;
    logic [PC_W-1:0]      pc_next;
    logic [DATA_W-1:0]    acc_next;

    assign op        = ir[7:4];
    assign imem_addr = pc;
    assign reg_idx   = ir[REG_IDX_W-1:0];
    assign imm       = {4'b0000, ir[3:0]};

`ifdef DP_R0_ZERO_EN
    assign reg_rd = (reg_idx == '0) ? '0 : regs[reg_idx];
    assign reg_we = LoadReg && (reg_idx != '0);
`else
    assign reg_rd = regs[reg_idx];
    assign reg_we = LoadReg;
`endif

    cpu_alu u_alu (
        .a    (acc),
        .b    (reg_rd),
        .sel  (SelALU),
        .y    (alu_y),
        .cout (alu_cout)
    );

    always_comb begin
        jump_cond = 1'b0;
        case (op)
            OP_JZ, OP_JZIM: jump_cond = z;
            OP_JC, OP_JCIM: jump_cond = c;
            default:        jump_cond = 1'b0;
        endcase
    end

    // A taken jump overrides a simultaneous increment.
    always_comb begin
        pc_next = pc;
        if (LoadPC && jump_cond) begin
            pc_next = SelPC ? reg_rd : imm;
        end else if (IncPC) begin
            pc_next = pc + 8'd1;
        end
    end

    always_comb begin
        acc_next = acc;
        case (acc_src_e'(SelACC))
            ACC_SRC_ALU:  acc_next = alu_y;
            ACC_SRC_REG:  acc_next = reg_rd;
            ACC_SRC_IMM:  acc_next = imm;
            default:      acc_next = acc;
        endcase
    end

    assign flag_we = LoadAcc && (SelACC == ACC_SRC_ALU) && is_alu_op(SelALU);

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            pc  <= '0;
            ir  <= '0;
            acc <= '0;
            z   <= 1'b0;
            c   <= 1'b0;
        end else begin
            pc <= pc_next;
            if (LoadIR)  ir  <= imem_data;
            if (LoadAcc) acc <= acc_next;
            if (flag_we) begin
                z <= (alu_y == '0);
                c <= alu_cout;
            end
        end
    end

    // The register file captures the pre-edge ACC, even when ACC also loads.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_we) begin
            regs[reg_idx] <= acc;
        end
    end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath; expected values hand-derived.
// Internal ACC/PC/register values are observed hierarchically.
module tb_cpu_datapath;

    logic       clk, CLR;
    logic       LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
    logic [1:0] SelACC;
    logic [3:0] SelALU;
    logic [7:0] imem_data;
    logic [7:0] imem_addr;
    logic [3:0] op;
    logic       z, c;

    int vec_count  = 0;
    int miscompare = 0;

    localparam logic [5:0] C_IR    = 6'b100000;
    localparam logic [5:0] C_INC   = 6'b010000;
    localparam logic [5:0] C_SELPC = 6'b001000;
    localparam logic [5:0] C_LPC   = 6'b000100;
    localparam logic [5:0] C_LREG  = 6'b000010;
    localparam logic [5:0] C_LACC  = 6'b000001;

    cpu_datapath dut (
        .clk       (clk),
        .CLR       (CLR),
        .LoadIR    (LoadIR),
        .IncPC     (IncPC),
        .SelPC     (SelPC),
        .LoadPC    (LoadPC),
        .LoadReg   (LoadReg),
        .LoadAcc   (LoadAcc),
        .SelACC    (SelACC),
        .SelALU    (SelALU),
        .imem_data (imem_data),
        .imem_addr (imem_addr),
        .op        (op),
        .z         (z),
        .c         (c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_controls(input logic [5:0] ctl, input logic [1:0] sacc,
                                input logic [3:0] salu, input logic [7:0] word);
        {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc} = ctl;
        SelACC    = sacc;
        SelALU    = salu;
        imem_data = word;
    endtask

    task automatic apply_stimulus(input logic [5:0] ctl, input logic [1:0] sacc,
                                  input logic [3:0] salu, input logic [7:0] word);
        set_controls(ctl, sacc, salu, word);
        @(posedge clk);
        #1;
        set_controls(6'b0, 2'b01, 4'b0000, 8'h00);
    endtask

    task automatic check_output(input string tag, input logic [7:0] got,
                                input logic [7:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompare++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic load_ir(input logic [7:0] w);
        apply_stimulus(C_IR, 2'b01, 4'b0000, w);
    endtask

    task automatic acc_alu(input logic [3:0] sel);
        apply_stimulus(C_LACC, 2'b00, sel, 8'h00);
    endtask

    task automatic acc_imm();
        apply_stimulus(C_LACC, 2'b11, 4'b0000, 8'h00);
    endtask

    task automatic reg_store();
        apply_stimulus(C_LREG, 2'b01, 4'b0000, 8'h00);
    endtask

    task automatic shl4();
        for (int i = 0; i < 4; i++) acc_alu(4'hB);
    endtask

    initial begin
        logic [7:0] r0_exp;
        CLR = 1'b1;
        set_controls(6'b0, 2'b01, 4'b0000, 8'h00);
        #12;
        check_output("rst_pc",   dut.pc, 8'h00);
        check_output("rst_addr", imem_addr, 8'h00);
        check_output("rst_op",   {4'h0, op}, 8'h00);
        check_output("rst_acc",  dut.acc, 8'h00);
        check_output("rst_z",    {7'b0, z}, 8'h00);
        check_output("rst_c",    {7'b0, c}, 8'h00);
        @(negedge clk);
        CLR = 1'b0;

        // R1 = 10, then ACC = F0
        load_ir(8'hD1); acc_imm(); shl4();
        check_output("shl_acc10", dut.acc, 8'h10);
        load_ir(8'h51); reg_store();
        check_output("r1_store", dut.regs[1], 8'h10);
        load_ir(8'hDF); acc_imm(); shl4();
        check_output("shl_accf0", dut.acc, 8'hF0);
        check_output("shl_c0",    {7'b0, c}, 8'h00);

        load_ir(8'h11); acc_alu(4'h1);
        check_output("add_acc", dut.acc, 8'h00);
        check_output("add_z",   {7'b0, z}, 8'h01);
        check_output("add_c",   {7'b0, c}, 8'h01);

        // R2 = 05, ACC = 03; LDIM must not disturb flags
        load_ir(8'hD5); acc_imm();
        load_ir(8'h52); reg_store();
        load_ir(8'hD3); acc_imm();
        check_output("ldim_acc", dut.acc, 8'h03);
        check_output("ldim_z",   {7'b0, z}, 8'h01);
        check_output("ldim_c",   {7'b0, c}, 8'h01);

        load_ir(8'h22); acc_alu(4'h2);
        check_output("sub_acc", dut.acc, 8'hFE);
        check_output("sub_z",   {7'b0, z}, 8'h00);
        check_output("sub_c",   {7'b0, c}, 8'h01);

        load_ir(8'h32); acc_alu(4'h3);
        check_output("nor_z", {7'b0, z}, 8'h01);
        check_output("nor_c", {7'b0, c}, 8'h00);

        load_ir(8'h79);
        check_output("op_jzim", {4'h0, op}, 8'h07);
        apply_stimulus(C_LPC, 2'b01, 4'h0, 8'h00);
        check_output("jz_taken", imem_addr, 8'h09);

        apply_stimulus(C_LACC, 2'b01, 4'h1, 8'h00);
        check_output("hold_acc", dut.acc, 8'h00);
        check_output("hold_z",   {7'b0, z}, 8'h01);

        apply_stimulus(C_INC, 2'b01, 4'h0, 8'h00);
        load_ir(8'hD1); acc_imm(); acc_alu(4'hB);
        check_output("shl_z0", {7'b0, z}, 8'h00);
        load_ir(8'h79);
        apply_stimulus(C_LPC, 2'b01, 4'h0, 8'h00);
        check_output("jz_not_taken", imem_addr, 8'h0A);
        apply_stimulus(C_INC | C_LPC, 2'b01, 4'h0, 8'h00);
        check_output("jz_nt_inc", imem_addr, 8'h0B);

        acc_alu(4'hC); acc_alu(4'hC);
        apply_stimulus(C_INC | C_LPC, 2'b01, 4'h0, 8'h00);
        check_output("jz_inc_taken", imem_addr, 8'h09);

        load_ir(8'h61);
        apply_stimulus(C_LPC | C_SELPC, 2'b01, 4'h0, 8'h00);
        check_output("jz_reg", imem_addr, 8'h10);
        load_ir(8'h8F);
        apply_stimulus(C_LPC, 2'b01, 4'h0, 8'h00);
        check_output("jc_taken", imem_addr, 8'h0F);

        // R3 = FF, jump there through c, then wrap
        load_ir(8'h30); acc_alu(4'h3);
        load_ir(8'h53); reg_store(); acc_alu(4'hB);
        load_ir(8'h83);
        apply_stimulus(C_LPC | C_SELPC, 2'b01, 4'h0, 8'h00);
        check_output("pc_ff", imem_addr, 8'hFF);
        apply_stimulus(C_INC, 2'b01, 4'h0, 8'h00);
        check_output("pc_wrap", imem_addr, 8'h00);

        load_ir(8'hD7); acc_imm();
        check_output("mova_acc", dut.acc, 8'h07);
        check_output("mova_z",   {7'b0, z}, 8'h00);
        check_output("mova_c",   {7'b0, c}, 8'h01);
        load_ir(8'h53); reg_store();
        check_output("r3_store", dut.regs[3], 8'h07);

        load_ir(8'hD9);
        apply_stimulus(C_LREG | C_LACC, 2'b11, 4'h0, 8'h00);
        check_output("coinc_r1",  dut.regs[1], 8'h07);
        check_output("coinc_acc", dut.acc, 8'h09);

`ifdef DP_R0_ZERO_EN
        r0_exp = 8'h00;
`else
        r0_exp = 8'h09;
`endif
        load_ir(8'h50); reg_store();
        load_ir(8'hA0);
        apply_stimulus(C_LACC, 2'b10, 4'h0, 8'h00);
        check_output("r0_read", dut.acc, r0_exp);

        apply_stimulus(C_IR | C_INC, 2'b01, 4'h0, 8'h31);
        check_output("irinc_op",  {4'h0, op}, 8'h03);
        check_output("irinc_pc",  imem_addr, 8'h01);

        // Build ACC = 5A: R2 = 0A, ACC = 50, add
        load_ir(8'hD5); acc_imm(); acc_alu(4'hB);
        load_ir(8'h52); reg_store();
        load_ir(8'hD5); acc_imm(); shl4();
        load_ir(8'h12); acc_alu(4'h1);
        check_output("acc_5a", dut.acc, 8'h5A);

        set_controls(C_LACC | C_INC | C_LREG, 2'b11, 4'h0, 8'h00);
        #3;
        CLR = 1'b1;
        #1;
        check_output("clr_acc",  dut.acc, 8'h00);
        check_output("clr_addr", imem_addr, 8'h00);
        check_output("clr_op",   {4'h0, op}, 8'h00);
        check_output("clr_r2",   dut.regs[2], 8'h00);
        check_output("clr_c",    {7'b0, c}, 8'h00);
        @(posedge clk);
        #1;
        check_output("clr_hold_acc", dut.acc, 8'h00);
        @(negedge clk);
        CLR = 1'b0;
        set_controls(6'b0, 2'b01, 4'h0, 8'h00);

        load_ir(8'hA5);
        check_output("post_clr_op",   {4'h0, op}, 8'h0A);
        check_output("post_clr_addr", imem_addr, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

endmodule
